// File: rtl/tcore_param.sv
// TCORE shared parameters and types.
// UART constants are common to the transmit and receive halves.
package tcore_param;

  localparam int UART_FIFO_DEPTH = 32;
  localparam int UART_DATA_BITS  = 8;
  localparam int UART_BAUD_W     = 16;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } uart_tx_state_e;

  // Divisors of 0 and 1 both mean one bit per enabled cycle.
  function automatic logic baud_hit(
    input logic [UART_BAUD_W-1:0] cnt,
    input logic [UART_BAUD_W-1:0] div
  );
    return (div <= 16'd1) || (cnt == div - 16'd1);
  endfunction

endpackage

// File: rtl/uart_fifo.sv
// Synchronous FIFO with occupancy count; shared by the UART halves.
// Storage is not reset, only the pointers and the count.
module uart_fifo #(
  parameter int DEPTH = 32,
  parameter int WIDTH = 8,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    level;
  logic             do_push;
  logic             do_pop;

  // full is judged before any same-cycle pop, so such a push is lost
  assign full    = (level == CW'(DEPTH));
  assign empty   = (level == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];
  assign count   = level;

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      unique case ({do_push, do_pop})
        2'b10:   level <= level + CW'(1);
        2'b01:   level <= level - CW'(1);
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: byte FIFO feeding an 8N1 serialiser.
// The line is registered and idles high.
module uart_tx
  import tcore_param::*;
#(
  parameter int FIFO_DEPTH = UART_FIFO_DEPTH,
  parameter int DATA_BITS  = UART_DATA_BITS
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [UART_BAUD_W-1:0] baud_div_i,
  input  logic                   tx_we_i,
  input  logic                   tx_en_i,
  input  logic [DATA_BITS-1:0]   din_i,
  output logic                   full_o,
  output logic                   empty_o,
  output logic                   busy_o,
  output logic                   tx_bit_o
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int BW = $clog2(DATA_BITS);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

  uart_tx_state_e         state;
  logic [DATA_BITS-1:0]   head;
  logic [DATA_BITS-1:0]   shift;
  logic [BW-1:0]          bit_cnt;
  logic [UART_BAUD_W-1:0] baud_cnt;
  logic [CW-1:0]          level;
  logic                   full;
  logic                   empty;
  logic                   run;
  logic                   tick;
  logic                   ready;
  logic                   load;
  logic                   tx_bit;

  uart_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DATA_BITS)
  ) u_fifo (
    .clk   (clk_i),
    .rst   (rst_i),
    .push  (tx_we_i),
    .pop   (load),
    .din   (din_i),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .count (level)
  );

  assign run   = tx_en_i && (state != IDLE);
  assign tick  = run && baud_hit(baud_cnt, baud_div_i);
  assign ready = (level != '0) && tx_en_i;
  assign load  = ready &&
                 ((state == IDLE) ||
                  ((state == STOP) && tick));

  assign full_o   = full;
  assign empty_o  = empty;
  assign busy_o   = (state != IDLE);
  assign tx_bit_o = tx_bit;

  // Cleared on load so the start bit is always a whole period.
  always_ff @(posedge clk_i) begin
    if (rst_i || load || tick) begin
      baud_cnt <= '0;
    end else if (run) begin
      baud_cnt <= baud_cnt + 16'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state   <= IDLE;
      shift   <= '0;
      bit_cnt <= '0;
      tx_bit  <= 1'b1;
    end else begin
      unique case (state)
        IDLE: begin
          if (load) begin
            shift   <= head;
            bit_cnt <= '0;
            tx_bit  <= 1'b0;
            state   <= START;
          end
        end
        START: begin
          if (tick) begin
            tx_bit <= shift[0];
            state  <= DATA;
          end
        end
        DATA: begin
          if (tick) begin
            shift   <= shift >> 1;
            bit_cnt <= bit_cnt + BW'(1);
            if (bit_cnt == LAST_BIT) begin
              tx_bit <= 1'b1;
              state  <= STOP;
            end else begin
              tx_bit <= shift[1];
            end
          end
        end
        STOP: begin
          if (load) begin
            shift   <= head;
            bit_cnt <= '0;
            tx_bit  <= 1'b0;
            state   <= START;
          end else if (tick) begin
            tx_bit <= 1'b1;
            state  <= IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: frame shape, back-to-back, overflow,
// enable pause, reset abort and the divisor-1/0 corner.
module tb_uart_tx;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] baud_div;
  logic        we;
  logic        en;
  logic [7:0]  din;
  logic        full;
  logic        empty;
  logic        busy;
  logic        tx_bit;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  uart_tx dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .baud_div_i (baud_div),
    .tx_we_i    (we),
    .tx_en_i    (en),
    .din_i      (din),
    .full_o     (full),
    .empty_o    (empty),
    .busy_o     (busy),
    .tx_bit_o   (tx_bit)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle_check(input string tag);
    check({tag, ":tx"}, 32'(tx_bit), 32'd1);
    check({tag, ":busy"}, 32'(busy), 32'd0);
    check({tag, ":empty"}, 32'(empty), 32'd1);
    check({tag, ":full"}, 32'(full), 32'd0);
  endtask

  function automatic logic exp_bit(input logic [7:0] b, input int idx);
    if (idx == 0) return 1'b0;
    if (idx >= 9) return 1'b1;
    return b[idx-1];
  endfunction

  // Checks the line from the first start-bit cycle onward.
  task automatic frame(
    input logic [7:0] b,
    input int         div,
    input int         ncyc,
    input int         pause_at,
    input int         pause_len,
    input bit         push_last,
    input logic [7:0] push_val,
    input string      tag
  );
    int len;
    len = (ncyc < 0) ? 10 * div : ncyc;
    for (int i = 0; i < len; i++) begin
      if (i == pause_at) begin
        en = 1'b0;
        for (int p = 0; p < pause_len; p++) begin
          check($sformatf("%s:hold%0d", tag, p),
                32'(tx_bit), 32'(exp_bit(b, i / div)));
          check($sformatf("%s:hbusy%0d", tag, p), 32'(busy), 32'd1);
          step();
        end
        en = 1'b1;
      end
      check($sformatf("%s:bit%0d", tag, i),
            32'(tx_bit), 32'(exp_bit(b, i / div)));
      check($sformatf("%s:busy%0d", tag, i), 32'(busy), 32'd1);
      if (push_last && i == len - 1) begin
        we  = 1'b1;
        din = push_val;
      end
      step();
      we = 1'b0;
    end
  endtask

  initial begin
    rst      = 1'b1;
    we       = 1'b0;
    en       = 1'b0;
    din      = 8'h00;
    baud_div = 16'd4;
    step();
    step();
    idle_check("reset");
    rst = 1'b0;

    // single byte, divisor 4
    en  = 1'b1;
    we  = 1'b1;
    din = 8'hA5;
    step();
    we = 1'b0;
    check("t1:empty_after_push", 32'(empty), 32'd0);
    check("t1:tx_before_pop", 32'(tx_bit), 32'd1);
    step();
    frame(8'hA5, 4, -1, -1, 0, 1'b0, 8'h00, "t1");
    idle_check("t1:end");

    // back-to-back, pushes on consecutive cycles
    baud_div = 16'd2;
    we  = 1'b1;
    din = 8'h00;
    step();
    din = 8'hFF;
    step();
    check("t2:start_latency", 32'(tx_bit), 32'd0);
    din = 8'h55;
    frame(8'h00, 2, -1, -1, 0, 1'b0, 8'h00, "t2a");
    frame(8'hFF, 2, -1, -1, 0, 1'b0, 8'h00, "t2b");
    frame(8'h55, 2, -1, -1, 0, 1'b0, 8'h00, "t2c");
    idle_check("t2:end");

    // fill to full while disabled, 33rd push dropped
    en = 1'b0;
    for (int i = 0; i < 32; i++) begin
      we  = 1'b1;
      din = 8'(i);
      step();
    end
    we = 1'b0;
    check("t3:full32", 32'(full), 32'd1);
    check("t3:not_empty", 32'(empty), 32'd0);
    we  = 1'b1;
    din = 8'h20;
    step();
    we = 1'b0;
    check("t3:still_full", 32'(full), 32'd1);
    check("t3:no_busy", 32'(busy), 32'd0);
    check("t3:line_idle", 32'(tx_bit), 32'd1);
    en = 1'b1;
    step();
    for (int k = 0; k < 32; k++) begin
      frame(8'(k), 2, -1, -1, 0, 1'b0, 8'h00, $sformatf("t3f%0d", k));
    end
    idle_check("t3:end");

    // push while full coinciding with a STOP-state pop
    en = 1'b0;
    for (int i = 0; i < 32; i++) begin
      we  = 1'b1;
      din = 8'(8'h40 + i);
      step();
    end
    we = 1'b0;
    check("t4:full", 32'(full), 32'd1);
    en = 1'b1;
    step();
    check("t4:first_pop", 32'(full), 32'd0);
    we  = 1'b1;
    din = 8'h60;
    frame(8'h40, 2, -1, -1, 0, 1'b1, 8'h61, "t4");
    check("t4:drop_count31", 32'(full), 32'd0);
    check("t4:next_start", 32'(tx_bit), 32'd0);
    check("t4:busy", 32'(busy), 32'd1);
    we  = 1'b1;
    din = 8'h62;
    step();
    we = 1'b0;
    check("t4:refull", 32'(full), 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    idle_check("t4:rst");

    // enable dropped for 20 cycles inside data bit 3
    baud_div = 16'd8;
    we  = 1'b1;
    din = 8'h96;
    step();
    we = 1'b0;
    step();
    frame(8'h96, 8, -1, 36, 20, 1'b0, 8'h00, "t5");
    idle_check("t5:end");

    // reset during data bit 5, then a clean frame
    baud_div = 16'd4;
    we  = 1'b1;
    din = 8'hC3;
    step();
    we = 1'b0;
    step();
    frame(8'hC3, 4, 26, -1, 0, 1'b0, 8'h00, "t6a");
    rst = 1'b1;
    step();
    rst = 1'b0;
    idle_check("t6:rst");
    we  = 1'b1;
    din = 8'h3C;
    step();
    we = 1'b0;
    step();
    frame(8'h3C, 4, -1, -1, 0, 1'b0, 8'h00, "t6b");
    idle_check("t6:end");

    // divisor 1 and 0 both give one cycle per bit
    baud_div = 16'd1;
    we  = 1'b1;
    din = 8'h5A;
    step();
    we = 1'b0;
    step();
    frame(8'h5A, 1, -1, -1, 0, 1'b0, 8'h00, "t7a");
    idle_check("t7a:end");
    baud_div = 16'd0;
    we  = 1'b1;
    din = 8'h81;
    step();
    we = 1'b0;
    step();
    frame(8'h81, 1, -1, -1, 0, 1'b0, 8'h00, "t7b");
    idle_check("t7b:end");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
- Transmit half of the TCORE UART peripheral; produces the serial line that a receiving `uart_rx` samples.
- Bus-side writes push bytes into a 32-entry FIFO.
- A baud-tick FSM pops bytes and serialises each as an 8N1 frame: 1 start bit (0), 8 data bits LSB-first, 1 stop bit (1).
- Shares `baud_div_i` and enable semantics with the receiver, so both halves run off the same control register.

Parameters:
- FIFO_DEPTH, 32, number of byte entries; power of two, ≥2.
- DATA_BITS, 8, data bits per frame; fixed at 8 in this release.

Ports:
- clk_i  input  1  system clock; single clock domain.
- rst_i  input  1  synchronous, active-high reset.
- baud_div_i  input  16  clk_i cycles per serial bit.
- tx_we_i  input  1  push request for `din_i` into the FIFO.
- tx_en_i  input  1  transmitter enable; gates both the baud counter and frame start.
- din_i  input  8  byte to push.
- full_o  output  1  FIFO holds FIFO_DEPTH entries.
- empty_o  output  1  FIFO holds 0 entries.
- busy_o  output  1  FSM not in IDLE.
- tx_bit_o  output  1  serial line; idle high.

Behaviour:
- Reset (synchronous, active-high, when `rst_i`=1 at a clk_i edge):
  - `tx_bit_o`=1, `full_o`=0, `empty_o`=1, `busy_o`=0.
  - Read/write pointers, count, baud counter, bit counter and shift register all cleared.
  - FSM=IDLE.
  - FIFO contents not cleared.
  - Reset mid-frame aborts the frame; line returns high in the next cycle.
- FIFO:
  - 5-bit read/write pointers that wrap modulo FIFO_DEPTH, plus a 6-bit occupancy count. All 32 entries are usable.
  - Push occurs when `tx_we_i` && !`full_o`. A push while full is dropped silently with no state change.
  - Pop is internal only (FSM load).
  - Simultaneous push and pop: both occur; count unchanged. A push while full with a same-cycle pop is still dropped, because `full_o` is evaluated before the pop.
  - `full_o`/`empty_o` are combinational from count; they update in the cycle after the push/pop edge.
- Baud tick:
  - 16-bit counter, advances only while `tx_en_i`=1 and FSM≠IDLE.
  - When counter == `baud_div_i`−1: counter←0 and `tick`=1 for one cycle.
  - `baud_div_i` of 0 or 1 gives a tick every enabled cycle.
  - The counter is cleared on every frame load, so bit 0 is always a full period.
  - A change to `baud_div_i` mid-bit takes effect at the next compare.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: if !`empty_o` && `tx_en_i`, pop the head into an 8-bit shift register, clear the baud counter and bit counter, and go to START.
  - START: `tx_bit_o`=0; on tick go to DATA.
  - DATA: `tx_bit_o`=shift[0]. On tick, shift right and increment the bit counter; after the tick with bit counter==7, go to STOP.
  - STOP: `tx_bit_o`=1. On tick:
    - if !`empty_o` && `tx_en_i`, pop and go directly to START (back-to-back, no idle gap);
    - otherwise go to IDLE.
- Latency:
  - A push at edge N into an empty FIFO with the FSM idle gives: `empty_o`=0 after N; pop at N+1; `tx_bit_o`=0 after N+1.
  - One frame = 10×`baud_div_i` cycles.
- `tx_en_i` dropped mid-frame: the baud counter freezes and `tx_bit_o` holds the current bit (frame stretched, not aborted). Counting resumes on re-enable.
- `tx_bit_o` is registered; it never glitches within a cycle.

Decomposition:
- Add to `tcore_param`: `UART_FIFO_DEPTH`=32 and the typedef `uart_tx_state_e` {IDLE, START, DATA, STOP}. `uart_rx` may reuse the depth constant.
- One sub-module is natural: `uart_fifo`, a parameterised synchronous FIFO with push/pop/full/empty/count. `uart_tx` instantiates it, and it is later reusable by `uart_rx`.
- Baud counter and FSM stay inline.

Test Plan:
- Single byte: `baud_div_i`=4, `tx_en_i`=1, push 0xA5 → `tx_bit_o` low 2 cycles after the push edge, then 4-cycle bit periods 0|1,0,1,0,0,1,0,1|1. `busy_o` high for exactly 40 cycles, then IDLE and `empty_o`=1.
- Back-to-back: `baud_div_i`=2, push 0x00, 0xFF, 0x55 on consecutive cycles → 60 continuous cycles with no idle gap between frames. Stop bit high 2 cycles, then the next start bit immediately.
- Full/overflow: `tx_en_i`=0, push 33 bytes 0x00..0x20 → `full_o`=1 after the 32nd push and the 33rd is dropped. Enable → exactly bytes 0x00..0x1F emitted in order; `empty_o`=1 afterwards.
- Simultaneous push/pop at full: with 32 entries queued, push while the FSM pops in STOP → push dropped, count becomes 31.
- Enable pause: `baud_div_i`=8, drop `tx_en_i` for 20 cycles in the middle of data bit 3 → bit 3 lasts 28 cycles; all other bits 8; byte value correct.
- Reset mid-frame: assert `rst_i` during DATA bit 5 → next cycle `tx_bit_o`=1, `busy_o`=0, `empty_o`=1. A subsequent push of 0x3C transmits a clean frame.
